// File: rtl/audio_interp_streamer_pkg.sv
// Shared definitions for the audio interpolator and the NCO stage it feeds.
package audio_interp_streamer_pkg;

  localparam int DATA_W_DEF      = 32;
  localparam int ADDR_W_DEF      = 15;
  localparam int LAST_ADDR_DEF   = 30700;

  // Sample-rate plan: 25 MHz system clock, ~8 kHz audio, 16 sub-steps/sample.
  localparam int CLK_HZ          = 25_000_000;
  localparam int SAMPLE_HZ       = 8_000;
  localparam int SUB_LOG2_DEF    = 4;
  localparam int CLK_DIV_SUB_DEF = CLK_HZ / (SAMPLE_HZ << SUB_LOG2_DEF); // 195

  // Carrier tuning word for 7.1 MHz at 25 MHz: round(7.1e6 / 25e6 * 2^32).
  localparam logic [31:0] CARRIER_TW = 32'd1219770712;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME_CUR,
    ST_PRIME_NXT,
    ST_PRIME_DLT,
    ST_RUN
  } stream_state_e;

endpackage

// File: rtl/audio_interp_streamer_ramp.sv
// interp_ramp: holds the current/next samples and per-step delta, and walks
// dev_o from cur toward nxt, snapping exactly onto nxt at each sample boundary.
module interp_ramp
  import audio_interp_streamer_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int SUB_LOG2 = SUB_LOG2_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              load_cur_i,
  input  logic              load_nxt_i,
  input  logic              start_i,
  input  logic              step_i,
  input  logic              snap_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] dev_o,
  output logic              dev_valid_o
);

  logic [DATA_W-1:0]        cur_q, nxt_q, delta_q;
  logic signed [DATA_W:0]   diff_w;
  logic [DATA_W-1:0]        delta_w;

  // One extra bit keeps full-scale swings (e.g. min -> max) from overflowing;
  // the arithmetic shift floors toward -inf, and the result always fits DATA_W.
  assign diff_w  = $signed({nxt_q[DATA_W-1], nxt_q}) - $signed({cur_q[DATA_W-1], cur_q});
  assign delta_w = DATA_W'(diff_w >>> SUB_LOG2);

  // Sample registers, delta pipeline and the deviation accumulator.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cur_q       <= '0;
      nxt_q       <= '0;
      delta_q     <= '0;
      dev_o       <= '0;
      dev_valid_o <= 1'b0;
    end else if (clr_i) begin
      cur_q       <= '0;
      nxt_q       <= '0;
      delta_q     <= '0;
      dev_o       <= '0;
      dev_valid_o <= 1'b0;
    end else begin
      // Re-registered every cycle; settles one cycle after nxt is captured.
      delta_q <= delta_w;
      if (load_cur_i)  cur_q <= mem_data_i;
      else if (snap_i) cur_q <= nxt_q;
      if (load_nxt_i)  nxt_q <= mem_data_i;
      if (start_i) begin
        dev_o       <= cur_q;
        dev_valid_o <= 1'b1;
      end else if (snap_i) begin
        dev_o <= nxt_q;            // drop accumulated truncation error
      end else if (step_i) begin
        dev_o <= dev_o + delta_q;  // wraps modulo 2^DATA_W
      end
    end
  end

endmodule

// File: rtl/audio_interp_streamer.sv
// audio_interp_streamer: sequences the external sample memory and drives an
// linearly interpolated deviation word into the NCO phase adder.
module audio_interp_streamer
  import audio_interp_streamer_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int LAST_ADDR   = LAST_ADDR_DEF,
  parameter int CLK_DIV_SUB = CLK_DIV_SUB_DEF,
  parameter int SUB_LOG2    = SUB_LOG2_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] dev_o,
  output logic              dev_valid_o,
  output logic              sample_tick_o,
  output logic              wrap_o,
  output logic              led_o
);

  localparam int                SUB_W     = $clog2(CLK_DIV_SUB);
  localparam logic [SUB_W-1:0]  SUB_MAX   = SUB_W'(CLK_DIV_SUB - 1);
  localparam logic [SUB_LOG2-1:0] STEP_MAX = '1;
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(LAST_ADDR);

  stream_state_e       state_q, state_d;
  logic [SUB_W-1:0]    sub_q;
  logic [SUB_LOG2-1:0] step_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          fetch_pipe;   // [0]: address issued, [1]: data on the bus
  logic                tick_q, wrap_q;

  logic clr, load_cur, load_nxt, start, sub_tick, step, snap;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state: prime three cycles, then run until enable drops.
  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:      state_d = ST_PRIME_CUR;
        ST_PRIME_CUR: state_d = ST_PRIME_NXT;
        ST_PRIME_NXT: state_d = ST_PRIME_DLT;
        ST_PRIME_DLT: state_d = ST_RUN;
        ST_RUN:       state_d = ST_RUN;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  // Control strobes decoded from state and counters.
  always_comb begin
    clr      = ~enable_i;
    load_cur = 1'b0;
    load_nxt = fetch_pipe[1];
    start    = 1'b0;
    sub_tick = 1'b0;
    case (state_q)
      ST_PRIME_NXT: load_cur = 1'b1;
      ST_PRIME_DLT: begin
        load_nxt = 1'b1;
        start    = 1'b1;
      end
      ST_RUN:       sub_tick = (sub_q == SUB_MAX);
      default:      ;
    endcase
    step = sub_tick & (step_q != STEP_MAX);
    snap = sub_tick & (step_q == STEP_MAX);
  end

  // Sub-step/step counters, fetch address and the one-cycle pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sub_q      <= '0;
      step_q     <= '0;
      addr_q     <= '0;
      fetch_pipe <= '0;
      tick_q     <= 1'b0;
      wrap_q     <= 1'b0;
    end else if (!enable_i) begin
      sub_q      <= '0;
      step_q     <= '0;
      addr_q     <= '0;
      fetch_pipe <= '0;
      tick_q     <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      fetch_pipe <= {fetch_pipe[0], snap};
      tick_q     <= snap;
      wrap_q     <= snap & (addr_q == ADDR_LAST);
      if (state_q == ST_PRIME_CUR) addr_q <= ADDR_W'(1);
      else if (snap)               addr_q <= (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
      if (state_q == ST_RUN)       sub_q  <= sub_tick ? '0 : sub_q + 1'b1;
      if (step)                    step_q <= step_q + 1'b1;
      else if (snap)               step_q <= '0;
    end
  end

  interp_ramp #(
    .DATA_W   (DATA_W),
    .SUB_LOG2 (SUB_LOG2)
  ) u_ramp (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clr_i       (clr),
    .load_cur_i  (load_cur),
    .load_nxt_i  (load_nxt),
    .start_i     (start),
    .step_i      (step),
    .snap_i      (snap),
    .mem_data_i  (mem_data_i),
    .dev_o       (dev_o),
    .dev_valid_o (dev_valid_o)
  );

  assign mem_addr_o    = addr_q;
  assign sample_tick_o = tick_q;
  assign wrap_o        = wrap_q;
  assign led_o         = addr_q[ADDR_W-1];

endmodule

// File: tb/tb_audio_interp_streamer.sv
// Bench for audio_interp_streamer: directed ramps on a 4-entry memory,
// randomized memory contents against a closed-form model, enable drop,
// asynchronous reset, and the default-parameter sample period.
module tb_audio_interp_streamer;

  localparam int DW  = 32;
  localparam int AW  = 15;
  localparam int LA  = 3;
  localparam int CDS = 4;
  localparam int SL  = 2;
  localparam int NS  = LA + 1;          // samples in memory
  localparam int SPS = 1 << SL;         // sub-steps per sample
  localparam int SEG = CDS * SPS;       // clocks per sample

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  logic en2 = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data, dev;
  logic          dev_valid, tick, wrap, led;

  logic [14:0]   mem_addr2;
  logic [31:0]   mem_data2, dev2;
  logic          dev_valid2, tick2, wrap2, led2;

  logic [DW-1:0] mem [0:NS-1];

  always @(posedge clk) mem_data  <= mem[mem_addr[1:0]];
  always @(posedge clk) mem_data2 <= 32'(mem_addr2) * 32'd5;

  audio_interp_streamer #(
    .DATA_W(DW), .ADDR_W(AW), .LAST_ADDR(LA), .CLK_DIV_SUB(CDS), .SUB_LOG2(SL)
  ) u_dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .mem_addr_o(mem_addr),
    .mem_data_i(mem_data), .dev_o(dev), .dev_valid_o(dev_valid),
    .sample_tick_o(tick), .wrap_o(wrap), .led_o(led)
  );

  audio_interp_streamer u_dut_def (
    .clk_i(clk), .rst_i(rst), .enable_i(en2), .mem_addr_o(mem_addr2),
    .mem_data_i(mem_data2), .dev_o(dev2), .dev_valid_o(dev_valid2),
    .sample_tick_o(tick2), .wrap_o(wrap2), .led_o(led2)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Spec example points for memory {0,100,-100,7}, clocks after dev_valid_o rises.
  int            dir_t [13] = '{4, 8, 12, 16, 20, 32, 36, 44, 48, 52, 60, 64, 68};
  logic [DW-1:0] dir_v [13] = '{32'd25, 32'd50, 32'd75, 32'd100, 32'd50, -32'sd100,
                                -32'sd74, -32'sd22, 32'd7, 32'd5, 32'd1, 32'd0, 32'd25};

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic longint floor_div(input longint d, input longint q);
    longint r;
    r = d / q;
    if ((d % q) != 0 && d < 0) r = r - 1;
    return r;
  endfunction

  // Sample k ramps from s[k] toward s[k+1] in SPS equal floored steps.
  function automatic logic [DW-1:0] model_dev(input int t);
    int     k, j;
    longint c, n;
    k = t / SEG;
    j = (t % SEG) / CDS;
    c = longint'($signed(mem[k % NS]));
    n = longint'($signed(mem[(k + 1) % NS]));
    return DW'(c + longint'(j) * floor_div(n - c, longint'(SPS)));
  endfunction

  task automatic start_and_check(input int ncyc, input bit directed);
    int k;
    @(negedge clk); en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("prime_valid_low", 32'(dev_valid), 32'd0);
    end
    for (int t = 0; t < ncyc; t++) begin
      @(negedge clk);
      k = t / SEG;
      chk("dev",   dev, model_dev(t));
      chk("valid", 32'(dev_valid), 32'd1);
      chk("addr",  32'(mem_addr), 32'((k + 1) % NS));
      chk("led",   32'(led), 32'(((k + 1) % NS) >> (AW - 1)));
      chk("tick",  32'(tick), 32'(t > 0 && t % SEG == 0));
      chk("wrap",  32'(wrap), 32'(t > 0 && t % SEG == 0 && k % NS == LA));
      if (directed)
        for (int i = 0; i < 13; i++)
          if (dir_t[i] == t) chk("directed_dev", dev, dir_v[i]);
    end
  endtask

  // Called right after a negedge: drop enable, expect everything cleared next cycle.
  task automatic drop_and_check(input string tag);
    en = 1'b0;
    @(negedge clk);
    chk({tag, "_dev"},   dev, 32'd0);
    chk({tag, "_valid"}, 32'(dev_valid), 32'd0);
    chk({tag, "_addr"},  32'(mem_addr), 32'd0);
    chk({tag, "_tick"},  32'(tick), 32'd0);
    chk({tag, "_wrap"},  32'(wrap), 32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;
    mem[0] = 32'd0;
    mem[1] = 32'd100;
    mem[2] = -32'sd100;
    mem[3] = 32'd7;

    #1 rst = 1'b1;
    #20;
    chk("rst_dev",   dev, 32'd0);
    chk("rst_valid", 32'(dev_valid), 32'd0);
    chk("rst_addr",  32'(mem_addr), 32'd0);
    chk("rst_tick",  32'(tick), 32'd0);
    chk("rst_wrap",  32'(wrap), 32'd0);
    chk("rst_led",   32'(led), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("idle_valid", 32'(dev_valid), 32'd0);

    // Full directed walk: ramps, snap, wrap, then the 0 -> 100 ramp again.
    start_and_check(SEG * 5 + 4, 1'b1);
    drop_and_check("drop_run");

    // Drop mid-ramp at dev=50, then just before a snap, then just before a wrap.
    start_and_check(12, 1'b1);
    drop_and_check("drop_mid");
    start_and_check(SEG, 1'b1);
    drop_and_check("drop_snap");
    start_and_check(SEG * 3, 1'b1);
    drop_and_check("drop_wrap");

    // Random full-range samples exercise large deltas and modulo wrap of dev_o.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NS; i++) mem[i] = $urandom;
      if (r == 0) begin
        mem[0] = 32'h7FFF_FFF0;
        mem[1] = 32'h8000_0005;
      end
      start_and_check(SEG * NS + 8, 1'b0);
      drop_and_check("drop_rand");
    end

    // Asynchronous reset between edges while running.
    mem[0] = 32'd0; mem[1] = 32'd100; mem[2] = -32'sd100; mem[3] = 32'd7;
    start_and_check(SEG + 6, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_dev",   dev, 32'd0);
    chk("arst_valid", 32'(dev_valid), 32'd0);
    chk("arst_addr",  32'(mem_addr), 32'd0);
    chk("arst_tick",  32'(tick), 32'd0);
    en = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("arst_idle_valid", 32'(dev_valid), 32'd0);

    // Default parameters: sample_tick_o period must be 195 * 16 = 3120 clocks.
    en2 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk);
      if (tick2) seen = 1'b1;
    end
    chk("def_first_tick_seen", 32'(seen), 32'd1);
    for (int p = 0; p < 2; p++) begin
      n = 0;
      seen = 1'b0;
      while (!seen && n < 4000) begin
        @(negedge clk);
        n++;
        if (tick2) seen = 1'b1;
      end
      chk("def_tick_period", 32'(n), 32'd3120);
    end
    en2 = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/audio_interp_streamer.md
Name: audio_interp_streamer

Overview:
- Upstream stage of the single-NCO SSB/FM transmitter.
- Walks the 32-bit deviation sample memory at the audio rate and drives a smoothed frequency-deviation word into the NCO phase-accumulator adder.
- Replaces the raw 8 kHz staircase with linear interpolation: 2^SUB_LOG2 equal steps between samples, which suppresses sample-rate images around the carrier.
- The sample memory stays external (registered read, 1-cycle latency), so this block owns only sequencing and arithmetic.

Parameters:
- DATA_W, 32, width of sample and deviation words (two's complement)
- ADDR_W, 15, sample memory address width
- LAST_ADDR, 30700, highest sample address; playback wraps to 0 after it (must be >= 1)
- CLK_DIV_SUB, 195, clocks per interpolation sub-step (must be >= 4)
- SUB_LOG2, 4, log2 of sub-steps per sample; sample period = CLK_DIV_SUB * 2^SUB_LOG2 clocks (3120 clocks = 8.013 kHz at 25 MHz)

Ports:
- clk_i, input, 1, system clock (25 MHz)
- rst_i, input, 1, reset
- enable_i, input, 1, playback enable (level)
- mem_addr_o, output, ADDR_W, sample memory read address
- mem_data_i, input, DATA_W, sample memory read data, valid 1 cycle after mem_addr_o
- dev_o, output, DATA_W, interpolated deviation word to the NCO adder
- dev_valid_o, output, 1, dev_o is live playback data
- sample_tick_o, output, 1, 1-cycle pulse when dev_o lands exactly on a new sample
- wrap_o, output, 1, 1-cycle pulse when the fetch address wraps LAST_ADDR -> 0
- led_o, output, 1, mem_addr_o[ADDR_W-1], activity indicator

Interface (already decided):
- One clock, clk_i.
- rst_i is asynchronous and active-high.

Behaviour:
- Reset (async): all registers and outputs are 0; state IDLE.
- States: IDLE, PRIME_CUR, PRIME_NXT, PRIME_DLT, RUN.
- IDLE:
  - dev_o = 0, dev_valid_o = 0, mem_addr_o = 0.
  - If enable_i = 1 -> PRIME_CUR.
- PRIME_CUR: mem_addr_o = 0 issued -> PRIME_NXT.
- PRIME_NXT: cur <= mem_data_i; mem_addr_o = 1 -> PRIME_DLT.
- PRIME_DLT:
  - nxt <= mem_data_i.
  - Next cycle: delta registered, dev_o <= cur, dev_valid_o <= 1, sub/step counters = 0 -> RUN.
  - Latency from enable_i rise to dev_valid_o = 4 clocks.
- delta = (nxt - cur) computed in DATA_W+1 bits, arithmetic shift right SUB_LOG2, truncated to DATA_W. Floor semantics: -7 >>> 2 = -2.
- RUN:
  - sub counter counts 0..CLK_DIV_SUB-1; a sub-tick occurs on its wrap.
  - On a sub-tick with step < 2^SUB_LOG2-1: dev_o <= dev_o + delta (modulo 2^DATA_W); step++.
  - On a sub-tick with step = 2^SUB_LOG2-1, all in the same cycle:
    - dev_o <= nxt exactly (snap; discards truncation error); cur <= nxt; step <= 0.
    - sample_tick_o pulses.
    - mem_addr_o advances (LAST_ADDR -> 0 with wrap_o pulse, else +1).
  - nxt captured 1 cycle after the fetch; delta re-registered 1 cycle after that. Both complete before the next sub-tick (guaranteed by CLK_DIV_SUB >= 4).
  - Counters keep running through the fetch; no stall.
- mem_addr_o always holds the address of nxt once in RUN.
- enable_i low in any non-IDLE state:
  - Next cycle -> IDLE; dev_o and dev_valid_o cleared; counters and address reset to 0.
  - No pulses are emitted in that cycle.
- enable_i re-asserted: playback restarts from address 0 via the full prime sequence.
- rst_i mid-operation: immediate return to the reset state regardless of the clock.
- sample_tick_o and wrap_o are never asserted outside RUN.

Decomposition:
- Shared package (shared with the NCO stage):
  - state enum
  - DATA_W / ADDR_W defaults
  - sample-rate constants (25 MHz clock, 8 kHz target)
  - carrier tuning word
- One sub-module is natural: interp_ramp (cur/nxt/delta registers plus the dev_o accumulator with snap). The FSM, counters and address logic stay in the top.

Test Plan:
Common setup: CLK_DIV_SUB=4, SUB_LOG2=2, LAST_ADDR=3; memory model = {0, 100, -100, 7}, 1-cycle read latency.
1. Reset, then raise enable_i -> dev_valid_o rises exactly 4 clocks later with dev_o=0; mem_addr_o=1.
2. Ramp up -> dev_o = 0,25,50,75, then 100 each 4 clocks; sample_tick_o high only in the cycle dev_o becomes 100.
3. Negative ramp -> 100,50,0,-50, then -100. Next pair -> -100,-74,-48,-22, then 7 (snap corrects the truncation error).
4. Wrap -> wrap_o pulses once when mem_addr_o goes 3 -> 0. Ramp 7 -> 0 gives 7,5,3,1,0, then 0 -> 100 repeats scenario 2.
5. Drop enable_i mid-ramp (dev_o=50) -> next cycle dev_o=0, dev_valid_o=0, mem_addr_o=0, no pulses. Re-enable -> scenario 1 timing repeats.
6. Assert rst_i asynchronously between clock edges during RUN -> all outputs 0 immediately. Default parameters -> sample_tick_o period is 3120 clocks.
